asg_lin: RTL and testbench



---
 rtl/asg_lin_pkg.sv | 26 ++
 rtl/axi4_stream_if.sv | 27 ++
 rtl/asg_lin_sat.sv | 26 ++
 rtl/asg_lin.sv | 144 ++++++++++++++
 tb/tb_asg_lin.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asg_lin_pkg.sv
// asg_lin shared constants and the saturate helper.
// ASG_LIN_DITHER_EN selects the dithered rounding path in asg_lin.
package asg_lin_pkg;

   // Fraction bits of the gain are DWM - MUL_GUARD (1.0 = 2**(DWM-2)).
   localparam int MUL_GUARD = 2;

   typedef logic [15:0] lfsr_t;

   localparam lfsr_t LFSR_SEED = 16'hACE1;
   localparam lfsr_t LFSR_TAPS = 16'hB400;

   function automatic logic signed [31:0] sat(
      input logic signed [31:0] v,
      input int unsigned        w
   );
      logic signed [31:0] mx;
      logic signed [31:0] mn;
      mx = (32'sd1 <<< (w - 1)) - 32'sd1;
      mn = -(32'sd1 <<< (w - 1));
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-stream bundle: s drives the beat, d accepts it.
// DN lanes of type DT; single-lane use is the common case.
interface axi4_stream_if #(
   parameter int  DN = 1,
   parameter type DT = logic [7:0]
) (
   input logic ACLK,
   input logic ARESETn
);

   logic          TVALID;
   logic          TREADY;
   logic          TLAST;
   logic [DN-1:0] TKEEP;
   DT             TDATA;

   modport s (
      input  ACLK, ARESETn, TREADY,
      output TVALID, TLAST, TKEEP, TDATA
   );

   modport d (
      input  ACLK, ARESETn, TVALID, TLAST, TKEEP, TDATA,
      output TREADY
   );

endinterface

// File: rtl/asg_lin_sat.sv
// Signed add with one guard bit, then clamp to DWO bits.
// sat_o flags that the clamp changed the value.
module asg_lin_sat
   import asg_lin_pkg::*;
#(
   parameter int DWA = 16,
   parameter int DWB = 14,
   parameter int DWO = 14
) (
   input  logic signed [DWA-1:0] a_i,
   input  logic signed [DWB-1:0] b_i,
   output logic signed [DWO-1:0] y_o,
   output logic                  sat_o
);

   localparam int SW = DWA + 1;

   logic signed [SW-1:0] sum;
   logic signed [31:0]   cl;

   assign sum   = SW'(a_i) + SW'(b_i);
   assign cl    = sat(32'(sum), DWO);
   assign y_o   = DWO'(cl);
   assign sat_o = (cl != 32'(sum));

endmodule

// File: rtl/asg_lin.sv
// Gain, offset and saturation stage feeding the DAC mux.
// Define ASG_LIN_DITHER_EN to replace truncation by LFSR dithered rounding.
module asg_lin
   import asg_lin_pkg::*;
#(
   parameter int DWI = 14,
   parameter int DWO = 14,
   parameter int DWM = 16,
   parameter int DWS = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   axi4_stream_if.d              sti,
   axi4_stream_if.s              sto,
   input  logic                  ctl_rst,
   input  logic signed [DWM-1:0] cfg_mul,
   input  logic signed [DWO-1:0] cfg_sum,
   output logic        [DWS-1:0] sts_sat,
   output logic                  sts_ovf
);

   localparam int MW   = DWI + DWM;
   localparam int FRAC = DWM - MUL_GUARD;
   localparam int SW   = MW - FRAC;

   logic                  ena;
   logic signed [DWI-1:0] din;
   logic signed [MW-1:0]  mul;
   logic signed [MW-1:0]  mul_d;
   logic signed [MW-1:0]  mul_q;
   logic                  v1_d;
   logic                  v1_q;
   logic                  l1_q;
   logic signed [SW-1:0]  shf;
   logic signed [DWO-1:0] y;
   logic                  sat_f;
   logic                  vo_q;
   logic                  lo_q;
   logic                  ko_q;
   logic signed [DWO-1:0] dat_q;
   logic [DWS-1:0]        cnt_d;
   logic [DWS-1:0]        cnt_q;
   logic                  ovf_d;
   logic                  ovf_q;

   assign ena        = sto.TREADY | ~vo_q;
   assign sti.TREADY = ena;
   assign din        = sti.TDATA;
   assign mul        = MW'(din) * MW'(cfg_mul);
   assign v1_d       = sti.TVALID & (|sti.TKEEP);

`ifdef ASG_LIN_DITHER_EN
   lfsr_t lfsr_d;
   lfsr_t lfsr_q;

   assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
   assign mul_d  = mul + MW'(lfsr_q[FRAC-1:0]);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)              lfsr_q <= LFSR_SEED;
      else if (ctl_rst)       lfsr_q <= LFSR_SEED;
      else if (ena && v1_d)   lfsr_q <= lfsr_d;
   end
`else
   assign mul_d = mul;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q  <= 1'b0;
         l1_q  <= 1'b0;
         mul_q <= '0;
      end else if (ctl_rst) begin
         v1_q  <= 1'b0;
         l1_q  <= 1'b0;
      end else if (ena) begin
         v1_q  <= v1_d;
         l1_q  <= sti.TLAST & v1_d;
         mul_q <= mul_d;
      end
   end

   // Arithmetic shift floors; the upper product bits are pure sign copies.
   assign shf = SW'(mul_q >>> FRAC);

   asg_lin_sat #(
      .DWA (SW),
      .DWB (DWO),
      .DWO (DWO)
   ) u_sat (
      .a_i   (shf),
      .b_i   (cfg_sum),
      .y_o   (y),
      .sat_o (sat_f)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vo_q  <= 1'b0;
         lo_q  <= 1'b0;
         ko_q  <= 1'b0;
         dat_q <= '0;
      end else if (ctl_rst) begin
         vo_q  <= 1'b0;
         lo_q  <= 1'b0;
         ko_q  <= 1'b0;
      end else if (ena) begin
         vo_q  <= v1_q;
         lo_q  <= l1_q;
         ko_q  <= v1_q;
         dat_q <= y;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (ena && v1_q && sat_f && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
         ovf_d = ovf_q | (&cnt_d);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (ctl_rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign sto.TVALID = vo_q;
   assign sto.TLAST  = lo_q;
   assign sto.TKEEP  = ko_q ? '1 : '0;
   assign sto.TDATA  = dat_q;
   assign sts_sat    = cnt_q;
   assign sts_ovf    = ovf_q;

endmodule

// File: tb/tb_asg_lin.sv
// Self-checking bench for asg_lin: vector table, scoreboard queue,
// hand-written sequences for stall, soft clear, counter limit, async reset.
module tb_asg_lin;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic ctl_rst = 1'b0;
   logic signed [15:0] cfg_mul = 16'h4000;
   logic signed [13:0] cfg_sum = '0;
   logic [15:0] sts_sat;
   logic sts_ovf;

`ifdef ASG_LIN_DITHER_EN
   localparam bit DITH = 1'b1;
`else
   localparam bit DITH = 1'b0;
`endif

   axi4_stream_if #(.DN(1), .DT(logic signed [13:0])) sti (
      .ACLK(clk), .ARESETn(rstn));
   axi4_stream_if #(.DN(1), .DT(logic signed [13:0])) sto (
      .ACLK(clk), .ARESETn(rstn));

   asg_lin #(.DWI(14), .DWO(14), .DWM(16), .DWS(16)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .sti     (sti),
      .sto     (sto),
      .ctl_rst (ctl_rst),
      .cfg_mul (cfg_mul),
      .cfg_sum (cfg_sum),
      .sts_sat (sts_sat),
      .sts_ovf (sts_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [13:0] d;
      logic               l;
   } exp_t;

   typedef struct {
      logic signed [13:0] din;
      logic [15:0]        mul;
      logic signed [13:0] sum;
      logic signed [13:0] exp;
      bit                 sat;
   } vec_t;

   localparam int NV = 15;

   exp_t q[$];
   vec_t tbl [NV];
   int checks = 0;
   int failures = 0;
   int out_cnt = 0;
   longint acc = 0;
   bit hold_v = 0;
   logic signed [13:0] hold_d;
   logic hold_l;

   task automatic chk(input string n, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", n, got, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      if (rstn && sto.TVALID) begin
         if (hold_v) begin
            checks++;
            if (sto.TDATA !== hold_d || sto.TLAST !== hold_l) begin
               failures++;
               $display("FAIL stall_stable got=%0d/%0b exp=%0d/%0b",
                        sto.TDATA, sto.TLAST, hold_d, hold_l);
            end
         end
         if (sto.TREADY) begin
            exp_t e;
            int diff;
            out_cnt++;
            acc += longint'(sto.TDATA);
            checks++;
            hold_v = 0;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_out got=%0d", sto.TDATA);
            end else begin
               e = q.pop_front();
               diff = int'(sto.TDATA) - int'(e.d);
               if (!(diff == 0 || (DITH && diff >= -1 && diff <= 1)) ||
                   sto.TLAST !== e.l || sto.TKEEP !== 1'b1) begin
                  failures++;
                  $display("FAIL out_beat got=%0d/%0b/%0b exp=%0d/%0b/1",
                           sto.TDATA, sto.TLAST, sto.TKEEP, e.d, e.l);
               end
            end
         end else begin
            hold_v = 1;
            hold_d = sto.TDATA;
            hold_l = sto.TLAST;
         end
      end else begin
         hold_v = 0;
      end
   end

   task automatic send(input logic signed [13:0] d,
                       input logic signed [13:0] e,
                       input logic l, input logic k, input bit push);
      bit ok;
      ok = 0;
      sti.TVALID = 1'b1;
      sti.TDATA  = d;
      sti.TLAST  = l;
      sti.TKEEP  = k;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sti.TREADY) begin
            if (push) q.push_back('{e, l});
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout got=0 exp=1");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sti.TVALID = 1'b0;
      sti.TLAST  = 1'b0;
      sti.TKEEP  = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      chk("drain_left", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      ctl_rst = 1'b1;
      @(posedge clk);
      #1;
      ctl_rst = 1'b0;
   endtask

   initial begin
      int exp_sat;
      int base;

      tbl[0]  = '{14'sd1000,  16'h4000, 14'sd0,    14'sd1000,  0};
      tbl[1]  = '{-14'sd1000, 16'h4000, 14'sd0,    -14'sd1000, 0};
      tbl[2]  = '{14'sd0,     16'h4000, 14'sd0,    14'sd0,     0};
      tbl[3]  = '{14'sd8191,  16'h7FFF, 14'sd0,    14'sd8191,  1};
      tbl[4]  = '{14'sd8191,  16'h4000, 14'sd0,    14'sd8191,  0};
      tbl[5]  = '{14'h2000,   16'h4000, -14'sd100, 14'h2000,   1};
      tbl[6]  = '{-14'sd3,    16'h2000, 14'sd0,    -14'sd2,    0};
      tbl[7]  = '{14'sd3,     16'h2000, 14'sd0,    14'sd1,     0};
      tbl[8]  = '{14'sd100,   16'h4000, 14'sd50,   14'sd150,   0};
      tbl[9]  = '{14'sd8000,  16'h4000, 14'sd500,  14'sd8191,  1};
      tbl[10] = '{14'sd7,     16'hC000, 14'sd0,    -14'sd7,    0};
      tbl[11] = '{14'sd8191,  16'h4000, -14'sd1,   14'sd8190,  0};
      tbl[12] = '{14'sd8191,  16'h4000, 14'sd1,    14'sd8191,  1};
      tbl[13] = '{14'h2000,   16'h4000, 14'sd0,    14'h2000,   0};
      tbl[14] = '{14'h2000,   16'hC000, 14'sd0,    14'sd8191,  1};

      sti.TVALID = 1'b0;
      sti.TDATA  = '0;
      sti.TLAST  = 1'b0;
      sti.TKEEP  = 1'b1;
      sto.TREADY = 1'b1;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_tvalid", sto.TVALID, 0);
      chk("rst_tlast", sto.TLAST, 0);
      chk("rst_tkeep", sto.TKEEP, 0);
      chk("rst_tdata", sto.TDATA, 0);
      chk("rst_sat", sts_sat, 0);
      chk("rst_ovf", sts_ovf, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("rdy_after_rst", sti.TREADY, 1);

      exp_sat = 0;
      for (int i = 0; i < NV; i++) begin
         cfg_mul = tbl[i].mul;
         cfg_sum = tbl[i].sum;
         send(tbl[i].din, tbl[i].exp, i == NV - 1, 1'b1, 1);
         idle();
         drain();
         exp_sat += int'(tbl[i].sat);
         chk($sformatf("vec%0d_sat", i), sts_sat, exp_sat);
      end

      cfg_mul = 16'h4000;
      cfg_sum = '0;
      send(14'sd77, 14'sd77, 1'b0, 1'b1, 1);
      idle();
      @(negedge clk);
      chk("lat_1clk", sto.TVALID, 0);
      @(negedge clk);
      chk("lat_2clk", sto.TVALID, 1);
      drain();

      base = out_cnt;
      send(14'sd33, 14'sd33, 1'b0, 1'b0, 0);
      idle();
      repeat (4) @(posedge clk);
      #1;
      chk("keep0_dropped", out_cnt - base, 0);

      base = out_cnt;
      fork
         begin
            for (int i = 1; i <= 10; i++)
               send(14'(i), 14'(i), i == 10, 1'b1, 1);
            idle();
         end
         begin
            for (int i = 0; i < 100; i++) begin
               @(posedge clk);
               if (out_cnt - base >= 3) break;
            end
            #1;
            sto.TREADY = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("stall_tready", sti.TREADY, 0);
            end
            @(posedge clk);
            #1;
            sto.TREADY = 1'b1;
         end
      join
      drain();
      chk("bp_count", out_cnt - base, 10);

      pulse_clr();
      chk("clr_sat", sts_sat, 0);
      cfg_mul = 16'h7FFF;
      for (int i = 0; i < 3; i++)
         send(14'sd8191, 14'sd8191, 1'b0, 1'b1, 1);
      idle();
      drain();
      chk("sat3", sts_sat, 3);

      cfg_mul = 16'h4000;
      sto.TREADY = 1'b0;
      send(14'sd100, 14'sd100, 1'b0, 1'b1, 0);
      send(14'sd200, 14'sd200, 1'b0, 1'b1, 0);
      idle();
      chk("inflight_valid", sto.TVALID, 1);
      pulse_clr();
      chk("clr_tvalid", sto.TVALID, 0);
      chk("clr_sat0", sts_sat, 0);
      chk("clr_ovf0", sts_ovf, 0);
      sto.TREADY = 1'b1;
      base = out_cnt;
      repeat (4) @(posedge clk);
      #1;
      chk("clr_no_out", out_cnt - base, 0);
      send(14'sd300, 14'sd300, 1'b0, 1'b1, 1);
      send(14'sd400, 14'sd400, 1'b1, 1'b1, 1);
      idle();
      drain();

      pulse_clr();
      cfg_mul = 16'h7FFF;
      for (int i = 0; i < 65534; i++)
         send(14'sd8191, 14'sd8191, 1'b0, 1'b1, 1);
      idle();
      drain();
      chk("lim_sat_65534", sts_sat, 65534);
      chk("lim_ovf_0", sts_ovf, 0);
      send(14'sd8191, 14'sd8191, 1'b0, 1'b1, 1);
      idle();
      drain();
      chk("lim_sat_max", sts_sat, 65535);
      chk("lim_ovf_1", sts_ovf, 1);
      send(14'sd8191, 14'sd8191, 1'b0, 1'b1, 1);
      idle();
      drain();
      chk("lim_sat_hold", sts_sat, 65535);
      chk("lim_ovf_hold", sts_ovf, 1);

`ifdef ASG_LIN_DITHER_EN
      pulse_clr();
      cfg_mul = 16'h2000;
      acc = 0;
      for (int i = 0; i < 4096; i++)
         send(14'sd5, 14'sd2, 1'b0, 1'b1, 1);
      idle();
      drain();
      begin
         real avg;
         avg = real'(acc) / 4096.0;
         checks++;
         if (avg < 2.45 || avg > 2.55) begin
            failures++;
            $display("FAIL dither_avg got=%f exp=2.5", avg);
         end
      end
`endif

      cfg_mul = 16'h4000;
      sto.TREADY = 1'b0;
      send(14'sd55, 14'sd55, 1'b0, 1'b1, 0);
      idle();
      @(posedge clk);
      #3;
      chk("arst_pre_valid", sto.TVALID, 1);
      rstn = 1'b0;
      #1;
      chk("arst_tvalid", sto.TVALID, 0);
      chk("arst_tdata", sto.TDATA, 0);
      chk("arst_tkeep", sto.TKEEP, 0);
      chk("arst_sat", sts_sat, 0);
      chk("arst_ovf", sts_ovf, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      sto.TREADY = 1'b1;
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
